// File: rtl/wr_req_arbiter.sv
// wr_req_arbiter
//   Round-robin arbiter that merges NUM_REQ write requesters onto a single
//   CCI-P c1 transmit channel. It counts writes that have not yet been
//   acknowledged and can drain them on request.
//
// Ports
//   Clk, Resetb        clock, synchronous active-low reset
//   req_valid/addr/data per-requester write request (42-bit line address, 512-bit data)
//   req_ready          combinational one-hot (or zero) accept back to the requesters
//   c1TxAlmFull        c1 almost-full backpressure
//   c1tx_valid/addr/data/mdata  registered write request; mdata carries the requester index
//   c1rx_rspValid      one-cycle write response
//   flush, flush_done  drain request pulse / one-cycle drain-complete pulse
//   outstanding        count of un-acknowledged writes
//   rsp_err            sticky flag: response seen with nothing outstanding
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal arbitration, requests accepted
// ST_DRAIN | no new requests; waiting for outstanding writes to retire
// ST_DONE  | drain complete, flush_done high for this single cycle
module wr_req_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                   Clk,
  input  logic                   Resetb,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*42-1:0]  req_addr,
  input  logic [NUM_REQ*512-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   c1TxAlmFull,
  output logic                   c1tx_valid,
  output logic [41:0]            c1tx_addr,
  output logic [511:0]           c1tx_data,
  output logic [15:0]            c1tx_mdata,
  input  logic                   c1rx_rspValid,
  input  logic                   flush,
  output logic                   flush_done,
  output logic [8:0]             outstanding,
  output logic                   rsp_err
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             found;
  logic             accept;
  logic             rsp_dec;
  logic             rsp_orphan;

  // Search starts at rr_ptr and wraps, so the first valid requester found
  // is the lowest index at or after the pointer.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found     = 1'b1;
        grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign accept = Resetb && (state == ST_RUN) && !c1TxAlmFull &&
                  (outstanding < 9'(MAX_OUTSTANDING)) && found;

  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  // A response only retires a write when something is actually in flight;
  // with nothing outstanding and no accept to pair with it, it is an error.
  assign rsp_dec    = c1rx_rspValid && (outstanding != 9'd0);
  assign rsp_orphan = c1rx_rspValid && (outstanding == 9'd0) && !accept;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((outstanding == 9'd0) && !c1tx_valid) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetb) begin
      state       <= ST_RUN;
      rr_ptr      <= '0;
      outstanding <= '0;
      c1tx_valid  <= 1'b0;
      c1tx_addr   <= '0;
      c1tx_data   <= '0;
      c1tx_mdata  <= '0;
      flush_done  <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state_nxt == ST_DONE);
      c1tx_valid <= accept;

      if (accept) begin
        c1tx_addr  <= req_addr[int'(grant_idx)*42 +: 42];
        c1tx_data  <= req_data[int'(grant_idx)*512 +: 512];
        c1tx_mdata <= {14'h0, 2'(grant_idx)};
        rr_ptr     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      // Accept and response in the same cycle cancel out.
      if (accept && !c1rx_rspValid) begin
        outstanding <= outstanding + 9'd1;
      end else if (!accept && rsp_dec) begin
        outstanding <= outstanding - 9'd1;
      end

      if (rsp_orphan) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wr_req_arbiter.sv
module tb_wr_req_arbiter;

  localparam int N   = 2;
  localparam int MAX = 64;

  logic             Clk;
  logic             Resetb;
  logic [N-1:0]     req_valid;
  logic [N*42-1:0]  req_addr;
  logic [N*512-1:0] req_data;
  logic [N-1:0]     req_ready;
  logic             c1TxAlmFull;
  logic             c1tx_valid;
  logic [41:0]      c1tx_addr;
  logic [511:0]     c1tx_data;
  logic [15:0]      c1tx_mdata;
  logic             c1rx_rspValid;
  logic             flush;
  logic             flush_done;
  logic [8:0]       outstanding;
  logic             rsp_err;

  wr_req_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
    .Clk(Clk), .Resetb(Resetb),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .c1TxAlmFull(c1TxAlmFull),
    .c1tx_valid(c1tx_valid), .c1tx_addr(c1tx_addr), .c1tx_data(c1tx_data), .c1tx_mdata(c1tx_mdata),
    .c1rx_rspValid(c1rx_rspValid), .flush(flush), .flush_done(flush_done),
    .outstanding(outstanding), .rsp_err(rsp_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  typedef struct {
    int            due;
    logic [41:0]   a;
    logic [511:0]  d;
    logic [15:0]   m;
  } wr_t;
  wr_t exp_q[$];

  // requester side
  logic [N-1:0] pend;
  logic [41:0]  p_addr[N];
  logic [511:0] p_data[N];

  // reference model
  bit m_drain, m_done, m_err, m_fd, m_txv;
  int m_rr, m_outs;

  logic [N-1:0] last_ready;

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input logic [N-1:0] want, input logic alm, input logic rsp,
                      input logic fl, input logic rstb);
    logic [N-1:0] exp_rdy;
    int  g;
    bit  acc;
    bit  hit;
    bit  nxt_drain, nxt_done;
    for (int i = 0; i < N; i++) begin
      if (want[i] && !pend[i]) begin
        pend[i]   = 1'b1;
        p_addr[i] = {10'($urandom), $urandom};
        p_data[i] = rnd512();
      end
    end
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_addr[i*42 +: 42]   = p_addr[i];
      req_data[i*512 +: 512] = p_data[i];
    end
    c1TxAlmFull   = alm;
    c1rx_rspValid = rsp;
    flush         = fl;
    Resetb        = rstb;
    #2;

    acc = 0; g = 0; hit = 0; exp_rdy = '0;
    if (rstb && !m_drain && !m_done && !alm && m_outs < MAX) begin
      for (int k = 0; k < N; k++) begin
        if (!hit && pend[(m_rr + k) % N]) begin
          hit = 1; g = (m_rr + k) % N;
        end
      end
      acc = hit;
      if (acc) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);
    last_ready = req_ready;

    if (acc) begin
      exp_q.push_back('{due: cyc + 1, a: p_addr[g], d: p_data[g], m: 16'(g)});
      pend[g] = 1'b0;
    end

    if (!rstb) begin
      m_drain = 0; m_done = 0; m_rr = 0; m_outs = 0; m_err = 0; m_fd = 0; m_txv = 0;
    end else begin
      nxt_drain = m_drain; nxt_done = 0;
      if (m_done)                          nxt_drain = 0;
      else if (m_drain) begin
        if (m_outs == 0 && !m_txv) begin nxt_drain = 0; nxt_done = 1; end
      end else if (fl)                     nxt_drain = 1;
      if (acc && rsp) ;
      else if (acc) m_outs++;
      else if (rsp) begin
        if (m_outs > 0) m_outs--;
        else m_err = 1;
      end
      if (acc) m_rr = (g + 1) % N;
      m_drain = nxt_drain;
      m_done  = nxt_done;
      m_fd    = nxt_done;
      m_txv   = acc;
    end

    @(posedge Clk);
    #1;
    cyc++;
    chk("outstanding", outstanding, m_outs);
    chk("flush_done", flush_done, m_fd);
    chk("rsp_err", rsp_err, m_err);
  endtask

  task automatic do_reset();
    pend = '0;
    step('0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 0);
  endtask

  // Write-channel monitor: checks each presented write against the queue.
  always @(negedge Clk) begin
    if (mon_en) begin
      bit exp_v;
      wr_t e;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      checks++;
      if (c1tx_valid !== exp_v) begin
        failures++;
        $display("FAIL c1tx_valid actual=%0b required=%0b cyc=%0d", c1tx_valid, exp_v, cyc);
      end
      if (exp_v) begin
        e = exp_q.pop_front();
        if (c1tx_valid === 1'b1) begin
          checks++;
          if (c1tx_addr !== e.a || c1tx_data !== e.d || c1tx_mdata !== e.m) begin
            failures++;
            $display("FAIL c1tx_write actual addr=%0h mdata=%0h dlo=%0h required addr=%0h mdata=%0h dlo=%0h",
                     c1tx_addr, c1tx_mdata, c1tx_data[63:0], e.a, e.m, e.d[63:0]);
          end
        end
      end
    end
  end

  int fd_cnt;
  bit fd_at7;

  initial begin
    pend = '0;
    req_valid = '0; req_addr = '0; req_data = '0;
    c1TxAlmFull = 0; c1rx_rspValid = 0; flush = 0; Resetb = 0;
    m_drain = 0; m_done = 0; m_rr = 0; m_outs = 0; m_err = 0; m_fd = 0; m_txv = 0;
    @(posedge Clk);
    #1;
    step('0, 0, 0, 0, 0);
    mon_en = 1;
    step('0, 0, 0, 0, 0);

    // Scenario 1: alternating grants
    step(2'b11, 0, 0, 0, 1); chk("s1_g0", last_ready, 2'b01);
    step(2'b11, 0, 0, 0, 1); chk("s1_g1", last_ready, 2'b10);
    step(2'b11, 0, 0, 0, 1); chk("s1_g2", last_ready, 2'b01);
    step(2'b11, 0, 0, 0, 1); chk("s1_g3", last_ready, 2'b10);
    chk("s1_outs", outstanding, 4);

    // Scenario 2: almost-full backpressure
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1, 0, 0, 1);
      chk("s2_blocked", last_ready, 0);
    end
    step(2'b00, 0, 0, 0, 1);
    chk("s2_accept", last_ready, 2'b01);
    chk("s2_txv", c1tx_valid, 1);

    // Scenario 3: outstanding limit
    do_reset();
    for (int i = 0; i < MAX; i++) step(2'b01, 0, 0, 0, 1);
    chk("s3_outs_full", outstanding, MAX);
    step(2'b01, 0, 0, 0, 1); chk("s3_ready_full", last_ready, 0);
    step(2'b01, 0, 1, 0, 1); chk("s3_ready_rsp", last_ready, 0);
    chk("s3_outs_after_rsp", outstanding, MAX - 1);
    step(2'b01, 0, 0, 0, 1); chk("s3_accept_again", last_ready, 2'b01);

    // Scenario 4: accept and response together
    do_reset();
    for (int i = 0; i < 5; i++) step(2'b01, 0, 0, 0, 1);
    chk("s4_outs5", outstanding, 5);
    step(2'b01, 0, 1, 0, 1);
    chk("s4_accept", last_ready, 2'b01);
    chk("s4_outs_hold", outstanding, 5);

    // Scenario 5: flush with three responses
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b01, 0, 0, 0, 1);
    chk("s5_outs3", outstanding, 3);
    step(2'b00, 0, 0, 1, 1);
    fd_cnt = 0; fd_at7 = 0;
    for (int t = 1; t <= 8; t++) begin
      step(2'b01, 0, (t == 2 || t == 4 || t == 6), 0, 1);
      chk("s5_ready_drain", last_ready, 0);
      if (flush_done) fd_cnt++;
      if (t == 7) fd_at7 = flush_done;
    end
    chk("s5_fd_count", fd_cnt, 1);
    chk("s5_fd_at7", fd_at7, 1);
    step(2'b01, 0, 0, 0, 1);
    chk("s5_run_again", last_ready, 2'b01);

    // Scenario 6: orphan response, cleared by reset
    do_reset();
    step(2'b00, 0, 1, 0, 1);
    chk("s6_err", rsp_err, 1);
    chk("s6_outs0", outstanding, 0);
    step(2'b00, 0, 0, 0, 0);
    chk("s6_err_clr", rsp_err, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(N'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) != 0));
    end
    step('0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wr_req_arbiter.md
WR_REQ_ARBITER -- requirements
Module: wr_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning the number of write requesters (2..4).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 64, meaning the maximum number of un-acknowledged writes (power of 2, at most 256).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port Resetb, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: the per-requester write request.
REQ-006 The block SHALL have port req_addr, input, NUM_REQ*42 bits: the per-requester cache-line address (t_ccip_clAddr).
REQ-007 The block SHALL have port req_data, input, NUM_REQ*512 bits: the per-requester line data.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: the per-requester accept; it is combinational and one-hot or zero.
REQ-009 The block SHALL have port c1TxAlmFull, input, 1 bit: the CCI-P c1 almost-full backpressure.
REQ-010 The block SHALL have port c1tx_valid, output, 1 bit: the registered write-request valid.
REQ-011 The block SHALL have port c1tx_addr, output, 42 bits: the registered write address.
REQ-012 The block SHALL have port c1tx_data, output, 512 bits: the registered write data.
REQ-013 The block SHALL have port c1tx_mdata, output, 16 bits: {14'h0, granted requester index}.
REQ-014 The block SHALL have port c1rx_rspValid, input, 1 bit: a one-cycle write response.
REQ-015 The block SHALL have port flush, input, 1 bit: a drain request pulse.
REQ-016 The block SHALL have port flush_done, output, 1 bit: a one-cycle pulse when the drain completes.
REQ-017 The block SHALL have port outstanding, output, 9 bits: the current count of un-acknowledged writes.
REQ-018 The block SHALL have port rsp_err, output, 1 bit: a sticky error flag for a response received with zero outstanding.

Function
REQ-019 The block SHALL define accept as the condition state==RUN, !c1TxAlmFull, outstanding<MAX_OUTSTANDING and |req_valid.
REQ-020 On accept, the block SHALL assert req_ready[g] for exactly one requester g: the lowest index at or after rr_ptr, searching with wrap modulo NUM_REQ.
REQ-021 On accept, the block SHALL set rr_ptr to (g+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-022 The cycle after an accept, the block SHALL drive c1tx_valid=1 with c1tx_addr, c1tx_data and c1tx_mdata taken from requester g; otherwise c1tx_valid SHALL be 0, and addr/data/mdata SHALL hold their values.
REQ-023 The write latency from accept to c1tx_valid SHALL be exactly 1 cycle, and the block SHALL sustain 1 write per cycle.
REQ-024 The block SHALL update outstanding as follows: +1 on accept; -1 on c1rx_rspValid when outstanding>0; unchanged when both occur in the same cycle.
REQ-025 On c1rx_rspValid with outstanding==0 and no same-cycle accept, the block SHALL keep outstanding at 0 and set rsp_err=1; rsp_err SHALL clear only on reset.
REQ-026 The block SHALL implement a state machine with states RUN, DRAIN and DONE.
REQ-027 RUN SHALL transition to DRAIN on flush; an accept in that same cycle SHALL still complete.
REQ-028 In DRAIN, req_ready SHALL be all 0, and DRAIN SHALL transition to DONE when outstanding==0 and c1tx_valid==0.
REQ-029 DONE SHALL last exactly 1 cycle, assert flush_done=1 during it, then return to RUN.
REQ-030 The block SHALL ignore flush in DRAIN and DONE.
REQ-031 At outstanding==MAX_OUTSTANDING, req_ready SHALL be 0 until a response arrives; the accept may occur in the cycle after the response.
REQ-032 The block SHALL drop no request: a requester holds req_valid, req_addr and req_data stable until it sees req_ready.

Reset
REQ-033 When Resetb==0 at a rising Clk edge, the block SHALL set state=RUN, rr_ptr=0, outstanding=0, c1tx_valid=0, c1tx_addr=0, c1tx_data=0, c1tx_mdata=0, flush_done=0 and rsp_err=0.
REQ-034 While Resetb==0, req_ready SHALL be 0.
REQ-035 A reset mid-operation SHALL abandon all in-flight counts, and responses arriving after reset SHALL set rsp_err.

Verification
REQ-036 Scenario 1: with req_valid=2'b11 held for 4 cycles and no backpressure, grants SHALL be 0,1,0,1, c1tx_mdata SHALL be 0,1,0,1 one cycle later, and outstanding SHALL be 4.
REQ-037 Scenario 2: with c1TxAlmFull=1 for 3 cycles while req_valid[0]=1, req_ready SHALL be 0 for those cycles, then the accept SHALL occur in the first cycle with almFull=0 and c1tx_valid SHALL be 1 the following cycle.
REQ-038 Scenario 3: after 64 accepts with no responses, req_ready SHALL be 0 and outstanding SHALL be 64; one rspValid SHALL give outstanding=63, and the next accept SHALL be allowed.
REQ-039 Scenario 4: with an accept and rspValid in the same cycle at outstanding=5, outstanding SHALL remain 5.
REQ-040 Scenario 5: with flush at outstanding=3 and 3 responses at cycles +2, +4 and +6, req_ready SHALL stay 0 and flush_done SHALL pulse once at cycle +7, after which the block SHALL return to RUN.
REQ-041 Scenario 6: rspValid at outstanding=0 SHALL set rsp_err=1 and keep outstanding=0, and a Resetb low pulse SHALL clear rsp_err.
